// File: rtl/nexys_starship_pkg.sv
// Shared constants for the Nexys Starship damage scheduler: FSM state
// encoding, subsystem indices and the LFSR feedback polynomial.
package nexys_starship_pkg;

  // One-hot FSM encoding; each state bit maps directly onto a q_* output.
  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_ARM   = 5'b00010,
    ST_COUNT = 5'b00100,
    ST_PICK  = 5'b01000,
    ST_OVER  = 5'b10000
  } state_e;

  // Bit positions of each repairable subsystem in broken / break_pulse.
  localparam int SUB_TOP    = 0;
  localparam int SUB_BOTTOM = 1;
  localparam int SUB_LEFT   = 2;
  localparam int SUB_RIGHT  = 3;

  // 16-bit Galois feedback taps (maximal length).
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // One Galois step: shift right, fold the taps in when bit 0 falls out.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

endpackage

// File: rtl/nexys_starship_lfsr16.sv
// Free-running 16-bit Galois LFSR; the random source for break gaps,
// victim search start and repair hex codes.
module nexys_starship_lfsr16
  import nexys_starship_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q, lfsr_d;

  // Advance one step every cycle; reset only reloads the seed.
  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  // State register, seeded on synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/nexys_starship_damage_sched.sv
// Damage scheduler: after a pseudo-random gap, breaks one working
// subsystem (round-robin from a random start), hands out a repair hex,
// and ends the game when any subsystem stays broken too long.
module nexys_starship_damage_sched
  import nexys_starship_pkg::*;
#(
  parameter int          NUM_SUB      = 4,
  parameter int unsigned MIN_GAP      = 50_000_000,
  parameter logic [31:0] GAP_MASK     = 32'h03FF_FFFF,
  parameter int unsigned BROKEN_LIMIT = 500_000_000,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               play_flag,
  input  logic [NUM_SUB-1:0] broken,
  output logic [NUM_SUB-1:0] break_pulse,
  output logic [3:0]         break_hex,
  output logic               gameover,
  output logic [7:0]         fire_count,
  output logic               q_Idle,
  output logic               q_Arm,
  output logic               q_Count,
  output logic               q_Pick,
  output logic               q_Over
);

  localparam logic [31:0] MIN_GAP32 = 32'(MIN_GAP);
  localparam logic [31:0] LIMIT32   = 32'(BROKEN_LIMIT);

  // Reject parameter sets whose gap overflows 32 bits or that would stall.
  if ((64'(MIN_GAP) + 64'(GAP_MASK) > 64'hFFFF_FFFF) || (MIN_GAP == 0) ||
      (BROKEN_LIMIT == 0) || (SEED == 16'h0000) || (NUM_SUB < 1)) begin : g_param_err
    $error("nexys_starship_damage_sched: illegal parameter set");
  end

  logic [15:0] lfsr;

  nexys_starship_lfsr16 #(.SEED(SEED)) u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .lfsr  (lfsr)
  );

  state_e                     state_q, state_d;
  logic [31:0]                gap_q, gap_d;
  logic [NUM_SUB-1:0]         pulse_q, pulse_d;
  logic [3:0]                 hex_q, hex_d;
  logic                       go_q, go_d;
  logic [7:0]                 fc_q, fc_d;
  logic [NUM_SUB-1:0][31:0]   timer_q, timer_d;

  int                         rr_start;
  logic                       vfound;
  logic [NUM_SUB-1:0]         victim_oh;
  logic                       limit_hit;

  // Round-robin victim search: first working subsystem at or after a
  // random start, wrapping past the top index.
  always_comb begin
    rr_start  = int'(lfsr[1:0]) % NUM_SUB;
    vfound    = 1'b0;
    victim_oh = '0;
    for (int k = 0; k < NUM_SUB; k++) begin
      for (int i = 0; i < NUM_SUB; i++) begin
        if (!vfound && (i == (rr_start + k) % NUM_SUB) && !broken[i]) begin
          vfound       = 1'b1;
          victim_oh[i] = 1'b1;
        end
      end
    end
  end

  // Any subsystem that has sat broken for the full limit ends the game.
  always_comb begin
    limit_hit = 1'b0;
    for (int i = 0; i < NUM_SUB; i++) begin
      if (timer_q[i] == LIMIT32) limit_hit = 1'b1;
    end
  end

  // Next-state logic; overrides at the bottom encode the priority
  // play_flag drop > game over > PICK fire.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pulse_d = '0;
    hex_d   = hex_q;
    go_d    = go_q;
    fc_d    = fc_q;
    for (int i = 0; i < NUM_SUB; i++) begin
      if (!broken[i])                timer_d[i] = '0;
      else if (timer_q[i] == LIMIT32) timer_d[i] = timer_q[i];
      else                           timer_d[i] = timer_q[i] + 32'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        hex_d   = '0;
        go_d    = 1'b0;
        fc_d    = '0;
        gap_d   = '0;
        timer_d = '0;
        if (play_flag) state_d = ST_ARM;
      end
      ST_ARM: begin
        // Load gap-1 so COUNT spends exactly 'gap' cycles before PICK.
        gap_d   = MIN_GAP32 + ({16'b0, lfsr} & GAP_MASK) - 32'd1;
        state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (gap_q == 32'd0) state_d = ST_PICK;
        else                gap_d   = gap_q - 32'd1;
      end
      ST_PICK: begin
        state_d = ST_ARM;
        if (vfound) begin
          pulse_d = victim_oh;
          hex_d   = lfsr[7:4];
          if (fc_q != 8'hFF) fc_d = fc_q + 8'd1;
        end
      end
      ST_OVER: begin
        go_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // A timer at the limit beats a fire in the same PICK cycle.
    if (limit_hit && (state_q inside {ST_ARM, ST_COUNT, ST_PICK})) begin
      state_d = ST_OVER;
      go_d    = 1'b1;
      pulse_d = '0;
      hex_d   = hex_q;
      fc_d    = fc_q;
    end

    // Leaving the game always wins and wipes the per-game state.
    if (!play_flag) begin
      state_d = ST_IDLE;
      pulse_d = '0;
      hex_d   = '0;
      go_d    = 1'b0;
      fc_d    = '0;
      gap_d   = '0;
      timer_d = '0;
    end
  end

  // All scheduler state, cleared by synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      pulse_q <= '0;
      hex_q   <= '0;
      go_q    <= 1'b0;
      fc_q    <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      pulse_q <= pulse_d;
      hex_q   <= hex_d;
      go_q    <= go_d;
      fc_q    <= fc_d;
      timer_q <= timer_d;
    end
  end

  assign break_pulse = pulse_q;
  assign break_hex   = hex_q;
  assign gameover    = go_q;
  assign fire_count  = fc_q;
  assign q_Idle      = (state_q == ST_IDLE);
  assign q_Arm       = (state_q == ST_ARM);
  assign q_Count     = (state_q == ST_COUNT);
  assign q_Pick      = (state_q == ST_PICK);
  assign q_Over      = (state_q == ST_OVER);

endmodule

// File: tb/tb_nexys_starship_damage_sched.sv
// Bench for the damage scheduler with a short gap (4) and broken limit (10).
module tb_nexys_starship_damage_sched;

  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_ARM   = 5'b00010;
  localparam logic [4:0] S_COUNT = 5'b00100;
  localparam logic [4:0] S_PICK  = 5'b01000;
  localparam logic [4:0] S_OVER  = 5'b10000;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       play_flag = 1'b0;
  logic [3:0] broken = 4'b0000;
  logic [3:0] break_pulse;
  logic [3:0] break_hex;
  logic       gameover;
  logic [7:0] fire_count;
  logic       q_Idle, q_Arm, q_Count, q_Pick, q_Over;
  logic [4:0] st_w;

  assign st_w = {q_Over, q_Pick, q_Count, q_Arm, q_Idle};

  nexys_starship_damage_sched #(
    .NUM_SUB(4), .MIN_GAP(4), .GAP_MASK(32'h0), .BROKEN_LIMIT(10), .SEED(SEED)
  ) dut (
    .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .broken(broken),
    .break_pulse(break_pulse), .break_hex(break_hex), .gameover(gameover),
    .fire_count(fire_count), .q_Idle(q_Idle), .q_Arm(q_Arm), .q_Count(q_Count),
    .q_Pick(q_Pick), .q_Over(q_Over)
  );

  always #5 Clk = ~Clk;

  // Reference LFSR: 16-bit Galois, taps B400, seeded while Reset is high.
  logic [15:0] m_lfsr;
  always @(posedge Clk) begin
    if (Reset) m_lfsr <= SEED;
    else m_lfsr <= m_lfsr[0] ? ({1'b0, m_lfsr[15:1]} ^ 16'hB400) : {1'b0, m_lfsr[15:1]};
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       play;
    logic [3:0] brk;
    logic [4:0] st;
    logic [3:0] pulse;
    logic [3:0] hex;
    logic [7:0] fc;
    logic       go;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic pl, input logic [3:0] bk, input logic [4:0] s,
                              input logic [3:0] p, input logic [3:0] h, input logic [7:0] f,
                              input logic g);
    vec_t v;
    v.play = pl; v.brk = bk; v.st = s; v.pulse = p; v.hex = h; v.fc = f; v.go = g;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Bounded wait for the FSM to sit in PICK (sampled at negedge).
  task automatic wait_pick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (q_Pick) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_pick: got no PICK within 12 cycles, expected one");
    end
  endtask

  // Bounded wait for the next nonzero break_pulse.
  task automatic wait_pulse(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (break_pulse != 4'b0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_pulse: got no pulse within 12 cycles, expected one");
    end
  endtask

  initial begin
    logic [3:0]  hx[3];
    logic [3:0]  pl[3];
    logic [3:0]  ph;
    logic [3:0]  exp_oh;
    logic [3:0]  bk;
    logic [15:0] cap;
    int          start, idx, exp_fc, n;
    bit          ok, seen2, any;

    // Hand-stepped LFSR from ACE1: PICK cycles see B313, 562C, 8ED8.
    hx = '{4'h1, 4'h2, 4'hD};
    pl = '{4'b1000, 4'b0001, 4'b0001};

    // Test 1: steady play, a fire every 6 cycles.
    tbl.push_back(mk(1'b1, 4'h0, S_ARM, 4'h0, 4'h0, 8'd0, 1'b0));
    for (int p = 0; p < 3; p++) begin
      ph = (p == 0) ? 4'h0 : hx[p-1];
      repeat (4) tbl.push_back(mk(1'b1, 4'h0, S_COUNT, 4'h0, ph, 8'(p), 1'b0));
      tbl.push_back(mk(1'b1, 4'h0, S_PICK, 4'h0, ph, 8'(p), 1'b0));
      tbl.push_back(mk(1'b1, 4'h0, S_ARM, pl[p], hx[p], 8'(p + 1), 1'b0));
    end
    // Test 3: everything broken for 8 cycles spanning a PICK.
    repeat (4) tbl.push_back(mk(1'b1, 4'hF, S_COUNT, 4'h0, 4'hD, 8'd3, 1'b0));
    tbl.push_back(mk(1'b1, 4'hF, S_PICK,  4'h0, 4'hD, 8'd3, 1'b0));
    tbl.push_back(mk(1'b1, 4'hF, S_ARM,   4'h0, 4'hD, 8'd3, 1'b0));
    tbl.push_back(mk(1'b1, 4'hF, S_COUNT, 4'h0, 4'hD, 8'd3, 1'b0));
    tbl.push_back(mk(1'b1, 4'hF, S_COUNT, 4'h0, 4'hD, 8'd3, 1'b0));
    tbl.push_back(mk(1'b1, 4'h0, S_COUNT, 4'h0, 4'hD, 8'd3, 1'b0));
    tbl.push_back(mk(1'b1, 4'h0, S_COUNT, 4'h0, 4'hD, 8'd3, 1'b0));

    // Reset for 3 cycles.
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_state", st_w, S_IDLE);
    chk("rst_pulse", break_pulse, 0);
    chk("rst_hex", break_hex, 0);
    chk("rst_gameover", gameover, 0);
    chk("rst_fire_count", fire_count, 0);
    Reset = 1'b0;

    for (int r = 0; r < tbl.size(); r++) begin
      play_flag = tbl[r].play;
      broken    = tbl[r].brk;
      tick();
      chk($sformatf("row%0d_state", r), st_w, tbl[r].st);
      chk($sformatf("row%0d_pulse", r), break_pulse, tbl[r].pulse);
      chk($sformatf("row%0d_hex", r), break_hex, tbl[r].hex);
      chk($sformatf("row%0d_fc", r), fire_count, tbl[r].fc);
      chk($sformatf("row%0d_go", r), gameover, tbl[r].go);
    end

    // Test 2: top two broken during PICK; search must wrap from start 2.
    exp_fc = 3;
    seen2  = 1'b0;
    bk     = 4'b1100;
    for (int it = 0; it < 60 && !seen2; it++) begin
      wait_pick(ok);
      if (!ok) break;
      broken = bk;
      cap    = m_lfsr;
      start  = int'(cap[1:0]);
      exp_oh = 4'b0000;
      for (int k = 0; k < 4; k++) begin
        idx = (start + k) % 4;
        if (exp_oh == 4'b0000 && ((bk >> idx) & 4'b0001) == 4'b0000) exp_oh = 4'b0001 << idx;
      end
      tick();
      broken = 4'b0000;
      exp_fc++;
      chk($sformatf("rr%0d_pulse_start%0d", it, start), break_pulse, exp_oh);
      chk($sformatf("rr%0d_hex", it), break_hex, cap[7:4]);
      chk($sformatf("rr%0d_fc", it), fire_count, exp_fc);
      if (start == 2) seen2 = 1'b1;
    end
    if (!seen2) begin
      checks++; errors++;
      $display("FAIL rr_start2: got no PICK with lfsr[1:0]=2, expected at least one");
    end

    // Test 4: subsystem 0 broken for 10 cycles ends the game.
    broken = 4'b0001;
    repeat (10) tick();
    broken = 4'b0000;
    chk("limit_go_before", gameover, 0);
    tick();
    chk("limit_go", gameover, 1);
    chk("limit_state", st_w, S_OVER);
    chk("limit_pulse", break_pulse, 0);
    any = 1'b0;
    repeat (6) begin
      tick();
      if (break_pulse != 4'b0 || !q_Over || !gameover) any = 1'b1;
    end
    chk("over_hold_no_pulse", any, 0);
    play_flag = 1'b0;
    tick();
    chk("over_exit_state", st_w, S_IDLE);
    chk("over_exit_go", gameover, 0);
    chk("over_exit_fc", fire_count, 0);

    // Test 5: play drops mid-COUNT.
    play_flag = 1'b1;
    tick();
    chk("drop_arm", st_w, S_ARM);
    tick();
    tick();
    chk("drop_count", st_w, S_COUNT);
    play_flag = 1'b0;
    tick();
    chk("drop_idle", st_w, S_IDLE);
    any = 1'b0;
    repeat (8) begin
      tick();
      if (break_pulse != 4'b0 || !q_Idle) any = 1'b1;
    end
    chk("drop_no_pulse", any, 0);

    // Reset mid-OVER (one fire happens first so hex/count are nonzero).
    play_flag = 1'b1;
    broken    = 4'b0001;
    repeat (13) tick();
    chk("rst_over_pre_state", st_w, S_OVER);
    chk("rst_over_pre_fc", fire_count, 1);
    Reset = 1'b1;
    tick();
    chk("rst_over_state", st_w, S_IDLE);
    chk("rst_over_pulse", break_pulse, 0);
    chk("rst_over_hex", break_hex, 0);
    chk("rst_over_go", gameover, 0);
    chk("rst_over_fc", fire_count, 0);
    Reset  = 1'b0;
    broken = 4'b0000;

    // Test 6: fire_count saturates at 255.
    n   = 0;
    any = 1'b0;
    for (int f = 0; f < 257; f++) begin
      wait_pulse(ok);
      if (!ok) break;
      n++;
      if (!$onehot(break_pulse)) any = 1'b1;
      if (n == 1 || n == 254 || n == 255 || n == 256 || n == 257)
        chk($sformatf("sat_fc_%0d", n), fire_count, (n > 255) ? 255 : n);
    end
    chk("sat_onehot", any, 0);

    // Timer reaches the limit exactly in a PICK cycle.
    wait_pick(ok);
    tick();
    tick();
    broken = 4'b0001;
    repeat (10) tick();
    chk("pick_limit_in_pick", st_w, S_PICK);
    chk("pick_limit_go_before", gameover, 0);
    tick();
    chk("pick_limit_go", gameover, 1);
    chk("pick_limit_state", st_w, S_OVER);
    chk("pick_limit_pulse", break_pulse, 0);
    chk("pick_limit_fc", fire_count, 255);
    broken    = 4'b0000;
    play_flag = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
